// File: rtl/or_writeback.sv
// rtl/or_writeback.sv - drains the output SRAM into a 2-entry FIFO and streams the words to DRAM
module or_writeback #(
    parameter int SRAM_NUM = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W:0]          len,
    output logic                     CEN_or,
    output logic [SRAM_NUM-1:0]      WEN_or,
    output logic [ADDR_W-1:0]        A_or,
    input  logic [SRAM_NUM*16-1:0]   Q_or,
    output logic [SRAM_NUM*16-1:0]   data_o_DRAM,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = SRAM_NUM * 16;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, FLUSH, FIN} state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] addr_q, addr_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            inflight_q, inflight_last_q;
    logic [DW-1:0]   fifo_data_q [2];
    logic [1:0]      fifo_last_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q;

    logic            pop, push, issue, last_read, can_read, head_last;
    logic [2:0]      occ;

    assign valid_o   = (count_q != 2'd0);
    assign pop       = valid_o & ready_i;
    assign push      = inflight_q;
    assign head_last = fifo_last_q[rd_ptr_q];
    assign last_read = (addr_q == (len_q - ONE));

    // Words already buffered plus the one arriving next must leave room for a new read.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
    assign can_read  = pop ? (occ < 3'd3) : (occ < 3'd2);
    assign issue     = (state_q == READ) && can_read;

    assign WEN_or      = '1;
    assign data_o_DRAM = valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign last_o      = valid_o & head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    addr_d  = '0;
                    state_d = (len == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + ONE;
                    if (last_read) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && head_last) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CEN_or = ~issue;
        A_or   = addr_q[ADDR_W-1:0];
        busy   = (state_q == READ) || (state_q == FLUSH);
        done   = (state_q == FIN);
    end

    // Read data lands one cycle after the request; each entry carries its end-of-drain flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_last_q     <= 2'b00;
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue & last_read;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= Q_or;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_or_writeback.sv
// tb/tb_or_writeback.sv - randomized scoreboard bench for or_writeback
module tb_or_writeback;

    localparam int SRAM_NUM = 8;
    localparam int ADDR_W   = 7;
    localparam int DW       = SRAM_NUM * 16;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W:0]     len = '0;
    logic                CEN_or;
    logic [SRAM_NUM-1:0] WEN_or;
    logic [ADDR_W-1:0]   A_or;
    logic [DW-1:0]       Q_or = '0;
    logic [DW-1:0]       data_o_DRAM;
    logic                valid_o;
    logic                ready_i = 1'b1;
    logic                last_o;
    logic                busy;
    logic                done;

    or_writeback #(.SRAM_NUM(SRAM_NUM), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .CEN_or(CEN_or), .WEN_or(WEN_or), .A_or(A_or), .Q_or(Q_or),
        .data_o_DRAM(data_o_DRAM), .valid_o(valid_o), .ready_i(ready_i),
        .last_o(last_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (!CEN_or) Q_or <= mem[A_or];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         sb[$];
    beat_t         b_mon;
    int            n_checks = 0;
    int            n_fail = 0;
    int            reads_left = 0;
    int            next_addr = 0;
    int            outstanding = 0;
    int            accepted = 0;
    int            ready_mode = 0;
    int            cyc = 0;
    bit            done_pipe = 0;
    bit            zl_due = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},   CEN_or, 1);
        check({tag, "_wen"},   WEN_or, {SRAM_NUM{1'b1}});
        check({tag, "_addr"},  A_or, 0);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_last"},  last_o, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_data"},  data_o_DRAM, 0);
    endtask

    // Ready patterns: 0 = always high, 1 = repeating 1,0,0, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ((cyc % 3) == 0);
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every drain must produce exactly the words mem[0..len-1] in order.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wen_ones", WEN_or, {SRAM_NUM{1'b1}});
            check("busy", busy, (sb.size() != 0));
            check("done", done, done_pipe | zl_due);
            done_pipe = 0;
            zl_due    = 0;
            if (prev_stall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o_DRAM, prev_data);
            end
            if (!CEN_or) begin
                if (reads_left == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_read: got read at %0d required no read", A_or);
                end else begin
                    check("read_addr", A_or, next_addr);
                    next_addr++;
                    reads_left--;
                end
                outstanding++;
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got %h required no beat", data_o_DRAM);
                end else begin
                    b_mon = sb.pop_front();
                    check("beat_data", data_o_DRAM, b_mon.data);
                    check("beat_last", last_o, b_mon.last);
                    if (b_mon.last) done_pipe = 1;
                end
                accepted++;
                outstanding--;
            end else if (valid_o) begin
                check("hold_last", last_o, (sb.size() == 1));
            end
            check("outstanding_le2", (outstanding <= 2), 1);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o_DRAM;
        end
    end

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_start(input int l, input bit accept);
        beat_t b;
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = (ADDR_W + 1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (accept) begin
            for (int i = 0; i < l; i++) begin
                b.data = mem[i];
                b.last = (i == l - 1);
                sb.push_back(b);
            end
            reads_left = l;
            next_addr  = 0;
            if (l == 0) zl_due = 1;
        end
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || reads_left != 0) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words pending required 0", tag, sb.size());
            sb.delete();
            reads_left = 0;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int base;
        int guard;
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        fill_random();
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Streaming drain with latency checks.
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'hA0 + i);
        ready_mode = 0;
        do_start(4, 1);
        @(negedge clk);
        check("lat_first_read", CEN_or, 0);
        check("lat_no_valid_e1", valid_o, 0);
        @(negedge clk);
        check("lat_no_valid_e2", valid_o, 0);
        @(negedge clk);
        check("lat_first_valid", valid_o, 1);
        check("lat_first_word", data_o_DRAM, DW'(32'hA0));
        wait_drain("stream");

        // Backpressure.
        fill_random();
        ready_mode = 1;
        do_start(6, 1);
        wait_drain("backpressure");

        // Zero length.
        ready_mode = 0;
        do_start(0, 1);
        wait_drain("zero_len");

        // Full depth.
        fill_random();
        do_start(DEPTH, 1);
        wait_drain("full_depth");

        // Start while busy is ignored.
        fill_random();
        ready_mode = 2;
        do_start(10, 1);
        repeat (3) @(posedge clk);
        do_start(3, 0);
        wait_drain("start_busy");

        // Reset after three words.
        fill_random();
        ready_mode = 0;
        base = accepted;
        do_start(8, 1);
        guard = 0;
        while (accepted < base + 3 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("rst_reached_3", (accepted >= base + 3), 1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        reads_left  = 0;
        outstanding = 0;
        done_pipe   = 0;
        zl_due      = 0;
        prev_stall  = 0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        do_start(2, 1);
        wait_drain("after_reset");

        // Random drains.
        for (int k = 0; k < 10; k++) begin
            fill_random();
            ready_mode = 2;
            do_start($urandom_range(0, 24), 1);
            wait_drain("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
